fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter_pkg.sv | 19 +
 rtl/fifo_write_arbiter_rr_pick.sv | 32 +++
 rtl/fifo_write_arbiter.sv | 93 +++++++++
 tb/tb_fifo_write_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// rtl/fifo_write_arbiter_pkg.sv - shared state encoding and sizing helper for the FIFO write arbiter
package fifo_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Smallest r with 2**r >= n; usable in parameter expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational round-robin search from a start index
module rr_pick
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [IW-1:0] o_winner,
    output logic          o_found
);

    // The winner is the requester at the smallest forward distance from i_start.
    always_comb begin
        int w_best;
        int w_dist;
        w_best   = N;
        w_dist   = 0;
        o_winner = '0;
        o_found  = 1'b0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j - int'(i_start) + N) % N;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best   = w_dist;
                o_winner = IW'(j);
                o_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter feeding one downstream FIFO write port
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int GW        = clog2(NUM_REQ),
    localparam int CW        = clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ-1:0]       i_req_last,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic                     i_fifo_full,
    output logic                     o_fifo_write,
    output logic [WIDTH-1:0]         o_fifo_write_data,
    output logic [GW-1:0]            o_grant_id,
    output logic                     o_busy
);

    state_t        r_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last_grant;
    logic [CW-1:0] r_burst_cnt;

    logic [GW-1:0] w_start;
    logic [GW-1:0] w_winner;
    logic          w_found;
    logic          w_locked;
    logic          w_xfer;

    assign w_start  = (r_last_grant == GW'(NUM_REQ - 1)) ? '0 : r_last_grant + 1'b1;
    assign w_locked = (r_state == ST_LOCKED) && !reset;
    assign w_xfer   = w_locked && i_req_valid[r_grant] && !i_fifo_full;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_rr_pick (
        .i_req    (i_req_valid),
        .i_start  (w_start),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    // Outputs are masked by reset so an abandoned burst cannot write in the reset cycle.
    always_comb begin
        o_fifo_write_data = '0;
        o_req_ready       = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_grant == GW'(j)) begin
                o_fifo_write_data = i_req_data[j*WIDTH +: WIDTH];
                o_req_ready[j]    = w_locked && !i_fifo_full;
            end
        end
    end

    assign o_fifo_write = w_xfer;
    assign o_grant_id   = r_grant;
    assign o_busy       = w_locked;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_burst_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state      <= ST_LOCKED;
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                        r_burst_cnt  <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        if (i_req_last[r_grant] || (r_burst_cnt == CW'(MAX_BURST - 1)))
                            r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - randomized scoreboard bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [N*W-1:0] req_data = '0;
    logic           fifo_full = 1'b0;
    logic [N-1:0]   req_ready;
    logic           fifo_write;
    logic [W-1:0]   wdata;
    logic [1:0]     grant_id;
    logic           busy;

    logic [1:0]     v2 = 2'b11;
    logic [1:0]     l2 = 2'b00;
    logic [15:0]    d2 = '0;
    logic           f2 = 1'b0;
    logic [1:0]     rdy2;
    logic           w2;
    logic [7:0]     wd2;
    logic           g2;
    logic           busy2;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .i_req_valid(req_valid), .i_req_last(req_last),
        .i_req_data(req_data), .o_req_ready(req_ready), .i_fifo_full(fifo_full),
        .o_fifo_write(fifo_write), .o_fifo_write_data(wdata), .o_grant_id(grant_id), .o_busy(busy)
    );

    fifo_write_arbiter #(.NUM_REQ(2), .WIDTH(8), .MAX_BURST(1)) dut2 (
        .clk(clk), .reset(reset), .i_req_valid(v2), .i_req_last(l2),
        .i_req_data(d2), .o_req_ready(rdy2), .i_fifo_full(f2),
        .o_fifo_write(w2), .o_fifo_write_data(wd2), .o_grant_id(g2), .o_busy(busy2)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {int id; int data;} wr_t;
    wr_t exp_q[$];

    int         m_owner = -1;
    int         m_last = N - 1;
    int         m_cnt = 0;
    bit         exp_busy = 1'b0;
    int         exp_grant = 0;
    logic [N-1:0] exp_ready = '0;
    bit         mon_en = 1'b0;
    int         exp2 = 0;
    int         writes2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: idle picks the next valid producer after the last winner; locked
    // moves one word per cycle when valid and not full, ending on last or MB words.
    task automatic model_step();
        bit found;
        int idx;
        exp_busy  = (m_owner >= 0) && !reset;
        exp_grant = m_owner;
        exp_ready = '0;
        if (reset) begin
            m_owner = -1;
            m_last  = N - 1;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!found && req_valid[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                    m_last  = idx;
                    m_cnt   = 0;
                end
            end
        end else begin
            if (!fifo_full) exp_ready[m_owner] = 1'b1;
            if (req_valid[m_owner] && !fifo_full) begin
                exp_q.push_back('{m_owner, int'(req_data[m_owner*W +: W])});
                m_cnt++;
                if (req_last[m_owner] || m_cnt == MB) m_owner = -1;
            end
        end
    endtask

    task automatic step(input bit rst, input logic [N-1:0] v, input logic [N-1:0] l, input bit full);
        @(posedge clk);
        #1;
        reset     = rst;
        req_valid = v;
        req_last  = l;
        fifo_full = full;
        req_data  = $urandom;
        d2        = 16'($urandom);
        model_step();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            wr_t e;
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            if (exp_busy) chk("grant_id", 32'(grant_id), exp_grant);
            chk("fifo_write", 32'(fifo_write), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (fifo_write === 1'b1) begin
                    chk("write_id", 32'(grant_id), e.id);
                    chk("write_data", 32'(wdata), e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                chk("mb1_write_in_reset", 32'(w2), 0);
                exp2 = 0;
            end else if (w2 === 1'b1) begin
                chk("mb1_grant", 32'(g2), exp2);
                chk("mb1_data", 32'(wd2), 32'(d2[exp2*8 +: 8]));
                writes2++;
                exp2 = 1 - exp2;
            end
        end
    end

    initial begin
        logic [N-1:0] l;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant", 32'(grant_id), 0);
        chk("reset_busy", 32'(busy), 0);
        mon_en = 1'b1;

        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        repeat (25) step(1'b0, 4'b1111, 4'b0000, 1'b0);

        for (int c = 0; c < 8; c++) begin
            l = (m_owner == 2 && m_cnt == 1) ? 4'b0100 : 4'b0000;
            step(1'b0, 4'b0100, l, 1'b0);
        end
        repeat (4) step(1'b0, 4'b1111, 4'b0000, 1'b0);

        for (int c = 0; c < 12; c++)
            step(1'b0, 4'b1111, 4'b0000, (c >= 3 && c < 6));

        for (int c = 0; c < 14; c++) begin
            l = (c == 10) ? 4'b0001 : 4'b0000;
            step(1'b0, (c >= 3 && c < 5) ? 4'b1000 : 4'b1001, l, 1'b0);
        end

        for (int c = 0; c < 2000; c++) begin
            l = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            step(($urandom_range(0, 99) == 0), 4'($urandom), l, ($urandom_range(0, 3) == 0));
        end

        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);
        chk("mb1_enough_writes", 32'(writes2 > 500), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
